// File: rtl/bp_me_lce_tr_scheduler.sv
// Trace-replay scheduler: feeds trace commands into one LCE, counts outstanding responses,
// and flags end-of-trace, hangs and protocol errors. BP_ME_TR_SCHED_CHECK_EN adds paddr ordering checks.
module bp_me_lce_tr_scheduler #(
    parameter int unsigned tr_ring_width_p   = 128,
    parameter int unsigned paddr_width_p     = 40,
    parameter int unsigned addr_lsb_p        = 1,
    parameter int unsigned max_outstanding_p = 4,
    parameter int unsigned timeout_cycles_p  = 1024
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     freeze_i,
    input  logic [tr_ring_width_p-1:0]               src_pkt_i,
    input  logic                                     src_v_i,
    input  logic                                     src_last_i,
    output logic                                     src_yumi_o,
    output logic [tr_ring_width_p-1:0]               tr_pkt_o,
    output logic                                     tr_pkt_v_o,
    input  logic                                     tr_pkt_ready_i,
    input  logic [tr_ring_width_p-1:0]               tr_resp_i,
    input  logic                                     tr_resp_v_i,
    output logic                                     tr_resp_yumi_o,
    output logic [$clog2(max_outstanding_p+1)-1:0]   outstanding_o,
    output logic [31:0]                              issued_o,
    output logic                                     done_o,
    output logic                                     error_o
);

    localparam int unsigned OutW  = $clog2(max_outstanding_p + 1);
    localparam int unsigned IdleW = $clog2(timeout_cycles_p + 1);
    localparam logic [OutW-1:0]  MaxOut     = OutW'(max_outstanding_p);
    localparam logic [IdleW-1:0] TimeoutVal = IdleW'(timeout_cycles_p);

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StDone, StError} state_e;

    state_e           state_q, state_d;
    logic [OutW-1:0]  outstanding_q, outstanding_d;
    logic [31:0]      issued_q, issued_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic             last_seen_q, last_seen_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             active, issue, resp_hs, resp_err, check_fail;
    logic             unused_resp;

    assign active = (state_q == StRun) || (state_q == StDrain);

    always_comb begin
        tr_pkt_o   = '0;
        tr_pkt_v_o = 1'b0;
        if (state_q == StRun) begin
            tr_pkt_o   = src_pkt_i;
            tr_pkt_v_o = src_v_i & ~freeze_i & (outstanding_q < MaxOut);
        end
    end

    assign issue          = tr_pkt_v_o & tr_pkt_ready_i;
    assign src_yumi_o     = issue;
    assign resp_hs        = active & tr_resp_v_i & (outstanding_q != '0);
    assign resp_err       = active & tr_resp_v_i & (outstanding_q == '0);
    assign tr_resp_yumi_o = resp_hs;
    assign unused_resp    = ^tr_resp_i;

`ifdef BP_ME_TR_SCHED_CHECK_EN
    localparam int unsigned PtrW = $clog2(max_outstanding_p);

    logic [paddr_width_p-1:0] fifo_q [max_outstanding_p];
    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(issue);
        rd_ptr_d = rd_ptr_q + PtrW'(resp_hs);
    end

    // A response is only accepted with outstanding>0, so the head entry is always valid here.
    assign check_fail = resp_hs
        & (tr_resp_i[addr_lsb_p +: paddr_width_p] != fifo_q[rd_ptr_q]);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue) begin
            fifo_q[wr_ptr_q] <= src_pkt_i[addr_lsb_p +: paddr_width_p];
        end
    end
`else
    assign check_fail = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        issued_d      = issued_q;
        idle_d        = idle_q;
        last_seen_d   = last_seen_q;

        if (issue && !resp_hs) begin
            outstanding_d = outstanding_q + OutW'(1);
        end else if (!issue && resp_hs) begin
            outstanding_d = outstanding_q - OutW'(1);
        end
        if (issue) begin
            issued_d = issued_q + 32'd1;
        end

        // Hang detector only runs while something is in flight and the bench is not frozen.
        if (resp_hs || (outstanding_q == '0)) begin
            idle_d = '0;
        end else if (active && !freeze_i) begin
            idle_d = idle_q + IdleW'(1);
        end

        unique case (state_q)
            StIdle:  if (!freeze_i) state_d = StRun;
            StRun: begin
                if (issue && src_last_i) begin
                    last_seen_d = 1'b1;
                    state_d     = StDrain;
                end
            end
            StDrain: if (outstanding_d == '0) state_d = StDone;
            default: ;
        endcase

        if (active && (resp_err || check_fail || (idle_d == TimeoutVal))) begin
            state_d = StError;
        end
    end

    assign done_d  = (state_d == StDone);
    assign error_d = (state_d == StError);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            outstanding_q <= '0;
            issued_q      <= '0;
            idle_q        <= '0;
            last_seen_q   <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            issued_q      <= issued_d;
            idle_q        <= idle_d;
            last_seen_q   <= last_seen_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign outstanding_o = outstanding_q;
    assign issued_o      = issued_q;
    assign done_o        = done_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_bp_me_lce_tr_scheduler.sv
// Directed bench for bp_me_lce_tr_scheduler; a small LCE responder replies after a set delay.
module tb_bp_me_lce_tr_scheduler;

    localparam int unsigned W       = 128;
    localparam int unsigned PW      = 40;
    localparam int unsigned Lsb     = 1;
    localparam int unsigned MaxOut  = 4;
    localparam int unsigned Timeout = 16;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          freeze_i;
    logic [W-1:0]  src_pkt_i;
    logic          src_v_i;
    logic          src_last_i;
    logic          src_yumi_o;
    logic [W-1:0]  tr_pkt_o;
    logic          tr_pkt_v_o;
    logic          tr_pkt_ready_i;
    logic [W-1:0]  tr_resp_i;
    logic          tr_resp_v_i;
    logic          tr_resp_yumi_o;
    logic [2:0]    outstanding_o;
    logic [31:0]   issued_o;
    logic          done_o;
    logic          error_o;

    bp_me_lce_tr_scheduler #(
        .tr_ring_width_p  (W),
        .paddr_width_p    (PW),
        .addr_lsb_p       (Lsb),
        .max_outstanding_p(MaxOut),
        .timeout_cycles_p (Timeout)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .freeze_i      (freeze_i),
        .src_pkt_i     (src_pkt_i),
        .src_v_i       (src_v_i),
        .src_last_i    (src_last_i),
        .src_yumi_o    (src_yumi_o),
        .tr_pkt_o      (tr_pkt_o),
        .tr_pkt_v_o    (tr_pkt_v_o),
        .tr_pkt_ready_i(tr_pkt_ready_i),
        .tr_resp_i     (tr_resp_i),
        .tr_resp_v_i   (tr_resp_v_i),
        .tr_resp_yumi_o(tr_resp_yumi_o),
        .outstanding_o (outstanding_o),
        .issued_o      (issued_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    int now, next_idx, n_cmds, n_resp, resp_delay;
    logic src_en, resp_en, force_resp, resp_swap, frz, iss_now, rsp_now;
    int due_q[$];
    logic [PW-1:0] addr_q[$];

    function automatic logic [W-1:0] mk_pkt(input logic [PW-1:0] a);
        logic [W-1:0] p;
        p = '0;
        p[W-1 -: 8] = 8'hA5;
        p[Lsb +: PW] = a;
        return p;
    endfunction

    function automatic logic [PW-1:0] addr_of(input int i);
        logic [PW-1:0] a;
        a = PW'((i + 1) * 4096);
        return a;
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1; freeze_i = 1'b0; src_v_i = 1'b0; src_last_i = 1'b0;
        src_pkt_i = '0; tr_resp_v_i = 1'b0; tr_resp_i = '0; tr_pkt_ready_i = 1'b1;
        due_q.delete(); addr_q.delete();
        now = 0; next_idx = 0; n_cmds = 0; n_resp = 0; resp_delay = 1;
        src_en = 1'b1; resp_en = 1'b1; force_resp = 1'b0; resp_swap = 1'b0; frz = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    // One cycle: drive source and LCE model at negedge, record handshakes just after.
    task automatic drive_cycle();
        logic [PW-1:0] ra;
        @(negedge clk_i);
        now++;
        freeze_i   = frz;
        src_v_i    = src_en && (next_idx < n_cmds);
        src_pkt_i  = mk_pkt(addr_of(next_idx));
        src_last_i = (next_idx == n_cmds - 1);
        ra = '0;
        if (addr_q.size() > 0) ra = resp_swap ? addr_q[addr_q.size()-1] : addr_q[0];
        tr_resp_v_i = force_resp || (resp_en && (due_q.size() > 0) && (due_q[0] <= now));
        tr_resp_i   = mk_pkt(ra);
        #1;
        iss_now = src_yumi_o;
        rsp_now = tr_resp_yumi_o;
        if (src_yumi_o) begin
            due_q.push_back(now + resp_delay);
            addr_q.push_back(addr_of(next_idx));
            next_idx++;
        end
        if (tr_resp_yumi_o && (due_q.size() > 0)) begin
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
            n_resp++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        reset_i = 1'b1; freeze_i = 1'b1; src_v_i = 1'b1; src_last_i = 1'b0;
        src_pkt_i = mk_pkt(40'h55); tr_resp_v_i = 1'b0; tr_resp_i = '0; tr_pkt_ready_i = 1'b1;
        @(negedge clk_i); #1;
        vectors++;
        if ({tr_pkt_v_o, src_yumi_o, tr_resp_yumi_o, done_o, error_o} !== 5'b0
            || tr_pkt_o !== '0 || outstanding_o !== 3'd0 || issued_o !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: v=%b yumi=%b ryumi=%b done=%b err=%b out=%0d iss=%0d want all 0",
                     tr_pkt_v_o, src_yumi_o, tr_resp_yumi_o, done_o, error_o, outstanding_o, issued_o);
        end
        reset_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i); #1;
        vectors++;
        if (tr_pkt_v_o !== 1'b0) begin
            miscompares++;
            $display("FAIL freeze_in_idle: tr_pkt_v_o=%b want 0", tr_pkt_v_o);
        end
        freeze_i = 1'b0;
        @(negedge clk_i); #1;
        vectors++;
        if (tr_pkt_v_o !== 1'b1 || tr_pkt_o !== mk_pkt(40'h55)) begin
            miscompares++;
            $display("FAIL start_after_freeze: v=%b pkt=%h want v=1 pkt=%h",
                     tr_pkt_v_o, tr_pkt_o, mk_pkt(40'h55));
        end
    endtask

    task automatic test_three_cmds();
        int peak = 0;
        int first_done = -1;
        do_reset();
        n_cmds = 3; resp_delay = 5;
        for (int i = 0; i < 40 && first_done < 0; i++) begin
            drive_cycle();
            if (int'(outstanding_o) > peak) peak = int'(outstanding_o);
            if (done_o) first_done = now;
        end
        vectors++;
        if (issued_o !== 32'd3) begin
            miscompares++;
            $display("FAIL three_issued: got %0d want 3", issued_o);
        end
        vectors++;
        if (peak != 3) begin
            miscompares++;
            $display("FAIL three_peak: got %0d want 3", peak);
        end
        // Issues at cycles 1..3, replies at 6..8, done visible the cycle after the last reply.
        vectors++;
        if (first_done != 9) begin
            miscompares++;
            $display("FAIL three_done_cycle: got %0d want 9", first_done);
        end
        vectors++;
        if (outstanding_o !== 3'd0 || error_o !== 1'b0 || n_resp != 3) begin
            miscompares++;
            $display("FAIL three_final: out=%0d err=%b resp=%0d want 0 0 3",
                     outstanding_o, error_o, n_resp);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        n_cmds = 8; resp_delay = 1; resp_en = 1'b0;
        for (int i = 0; i < 20 && next_idx < 4; i++) drive_cycle();
        drive_cycle();
        drive_cycle();
        vectors++;
        if (outstanding_o !== 3'd4 || tr_pkt_v_o !== 1'b0 || src_v_i !== 1'b1 || next_idx != 4) begin
            miscompares++;
            $display("FAIL b2b_stall: out=%0d v=%b issued=%0d want 4 0 4",
                     outstanding_o, tr_pkt_v_o, next_idx);
        end
        resp_en = 1'b1;
        drive_cycle();
        vectors++;
        if (rsp_now !== 1'b1 || iss_now !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first_resp: resp=%b issue=%b want 1 0", rsp_now, iss_now);
        end
        drive_cycle();
        vectors++;
        if (iss_now !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_resume: issue=%b want 1", iss_now);
        end
        for (int i = 0; i < 60 && !done_o; i++) drive_cycle();
        vectors++;
        if (done_o !== 1'b1 || issued_o !== 32'd8 || n_resp != 8) begin
            miscompares++;
            $display("FAIL b2b_done: done=%b iss=%0d resp=%0d want 1 8 8", done_o, issued_o, n_resp);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        n_cmds = 10; resp_delay = 1; resp_en = 1'b0;
        for (int i = 0; i < 10 && next_idx < 2; i++) drive_cycle();
        resp_en = 1'b1;
        drive_cycle();
        vectors++;
        if (iss_now !== 1'b1 || rsp_now !== 1'b1 || outstanding_o !== 3'd2) begin
            miscompares++;
            $display("FAIL same_cycle_hs: issue=%b resp=%b out=%0d want 1 1 2",
                     iss_now, rsp_now, outstanding_o);
        end
        src_en = 1'b0; resp_en = 1'b0;
        drive_cycle();
        vectors++;
        if (outstanding_o !== 3'd2) begin
            miscompares++;
            $display("FAIL same_cycle_count: got %0d want 2", outstanding_o);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        n_cmds = 3; resp_delay = 1; resp_en = 1'b0;
        drive_cycle();
        frz = 1'b1;
        drive_cycle();
        vectors++;
        if (tr_pkt_v_o !== 1'b0 || iss_now !== 1'b0) begin
            miscompares++;
            $display("FAIL freeze_no_issue: v=%b issue=%b want 0 0", tr_pkt_v_o, iss_now);
        end
        // Longer than the timeout: a paused counter must not fire.
        repeat (20) drive_cycle();
        vectors++;
        if (error_o !== 1'b0) begin
            miscompares++;
            $display("FAIL freeze_timeout_paused: error=%b want 0", error_o);
        end
        resp_en = 1'b1;
        drive_cycle();
        vectors++;
        if (rsp_now !== 1'b1) begin
            miscompares++;
            $display("FAIL freeze_resp_consumed: resp=%b want 1", rsp_now);
        end
        frz = 1'b0;
        drive_cycle();
        vectors++;
        if (iss_now !== 1'b1) begin
            miscompares++;
            $display("FAIL unfreeze_issue: issue=%b want 1", iss_now);
        end
    endtask

    task automatic test_timeout();
        int first_err = -1;
        do_reset();
        n_cmds = 5; resp_en = 1'b0;
        drive_cycle();
        src_en = 1'b0;
        for (int i = 0; i < 30 && first_err < 0; i++) begin
            drive_cycle();
            if (error_o) first_err = now;
        end
        // Issue in cycle 1; idle count reaches 16 in cycle 17, error visible in cycle 18.
        vectors++;
        if (first_err != 18 || done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_cycle: err_cycle=%0d done=%b want 18 0", first_err, done_o);
        end
        src_en = 1'b1; resp_en = 1'b1;
        drive_cycle();
        vectors++;
        if (tr_pkt_v_o !== 1'b0 || tr_resp_yumi_o !== 1'b0 || error_o !== 1'b1) begin
            miscompares++;
            $display("FAIL error_hold: v=%b ryumi=%b err=%b want 0 0 1",
                     tr_pkt_v_o, tr_resp_yumi_o, error_o);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        #1;
        vectors++;
        if (error_o !== 1'b0 || done_o !== 1'b0 || outstanding_o !== 3'd0 || issued_o !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset: err=%b done=%b out=%0d iss=%0d want 0 0 0 0",
                     error_o, done_o, outstanding_o, issued_o);
        end
    endtask

    task automatic test_unexpected_resp();
        do_reset();
        n_cmds = 0; force_resp = 1'b1;
        drive_cycle();
        vectors++;
        if (rsp_now !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_resp_yumi: got %b want 0", rsp_now);
        end
        force_resp = 1'b0;
        drive_cycle();
        vectors++;
        if (error_o !== 1'b1 || done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_resp_error: err=%b done=%b want 1 0", error_o, done_o);
        end
    endtask

    task automatic test_addr_order();
        do_reset();
        n_cmds = 2; resp_en = 1'b0; resp_swap = 1'b1;
        for (int i = 0; i < 10 && next_idx < 2; i++) drive_cycle();
        resp_en = 1'b1;
        for (int i = 0; i < 30 && !done_o && !error_o; i++) drive_cycle();
        vectors++;
`ifdef BP_ME_TR_SCHED_CHECK_EN
        if (error_o !== 1'b1 || done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL addr_order: err=%b done=%b want 1 0", error_o, done_o);
        end
`else
        if (done_o !== 1'b1 || error_o !== 1'b0) begin
            miscompares++;
            $display("FAIL addr_order: done=%b err=%b want 1 0", done_o, error_o);
        end
`endif
    endtask

    initial begin
        reset_i = 1'b1; freeze_i = 1'b0; src_v_i = 1'b0; src_last_i = 1'b0;
        src_pkt_i = '0; tr_resp_v_i = 1'b0; tr_resp_i = '0; tr_pkt_ready_i = 1'b1;
        test_reset();
        test_three_cmds();
        test_back_to_back();
        test_same_cycle();
        test_freeze();
        test_timeout();
        test_mid_reset();
        test_unexpected_resp();
        test_addr_order();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
